// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use, branch, memory-wait, watchdog.
// Optional stall cycle counter is built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       mem_branch,
    input  logic       mem_zero,
    input  logic       mem_memread,
    input  logic       mem_memwrite,
    input  logic       dmem_ack,
    output logic       pc_en,
    output logic       pc_sel_branch,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       dmem_req,
    output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam logic [7:0] WdLast = 8'(MEM_TIMEOUT - 1);

    logic [0:0] state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       mem_err_q, mem_err_d;

    logic mem_access;
    logic taken;
    logic load_use;
    logic apply_rules;
    logic plain_advance;

    assign mem_access = mem_memread | mem_memwrite;
    assign taken      = mem_branch & mem_zero;
    assign load_use   = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        mem_err_d     = mem_err_q;
        apply_rules   = 1'b0;
        plain_advance = 1'b0;
        pc_en         = 1'b0;
        pc_sel_branch = 1'b0;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        exmem_en      = 1'b0;
        memwb_en      = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        dmem_req      = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_access) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        apply_rules = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                        wd_d    = 8'd0;
                    end
                end else begin
                    apply_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    dmem_req    = 1'b1;
                    apply_rules = 1'b1;
                    state_d     = RUN;
                end else if (wd_q >= WdLast) begin
                    // Abandon the access: drop the request and let the pipeline move on.
                    mem_err_d     = 1'b1;
                    state_d       = RUN;
                    plain_advance = 1'b1;
                end else begin
                    dmem_req = 1'b1;
                    wd_d     = wd_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase

        if (apply_rules) begin
            if (taken) begin
                pc_sel_branch = 1'b1;
                pc_en         = 1'b1;
                ifid_en       = 1'b1;
                idex_en       = 1'b1;
                exmem_en      = 1'b1;
                memwb_en      = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                exmem_flush   = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
            end else begin
                plain_advance = 1'b1;
            end
        end

        if (plain_advance) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end

        if (reset) begin
            pc_en         = 1'b0;
            pc_sel_branch = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exmem_en      = 1'b0;
            memwb_en      = 1'b0;
            ifid_flush    = 1'b0;
            idex_flush    = 1'b0;
            exmem_flush   = 1'b0;
            dmem_req      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wd_q      <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (!pc_en) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle rule table plus multi-cycle memory sequences.
// Stall counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, mem_branch, mem_zero, mem_memread, mem_memwrite, dmem_ack;
    logic       pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, dmem_req, mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    int unsigned exp_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .mem_branch   (mem_branch),
        .mem_zero     (mem_zero),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .pc_sel_branch(pc_sel_branch),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .dmem_req     (dmem_req),
        .mem_err      (mem_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    // Output vector order: {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
    //                       ifid_flush, idex_flush, exmem_flush, dmem_req}
    localparam logic [9:0] ZERO   = 10'b0_0_0000_000_0;
    localparam logic [9:0] ADV    = 10'b1_0_1111_000_0;
    localparam logic [9:0] BRANCH = 10'b1_1_1111_111_0;
    localparam logic [9:0] LDUSE  = 10'b0_0_0111_010_0;
    localparam logic [9:0] FREEZE = 10'b0_0_0000_000_1;
    localparam logic [9:0] REQ    = 10'b0_0_0000_000_1;

    typedef struct {
        logic [4:0] rs, rt, ert;
        logic       emr, br, z, mr, mw, ack;
        logic [9:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic cyc(input string name, input logic rst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                       input logic emr, input logic br, input logic z,
                       input logic mr, input logic mw, input logic ack,
                       input logic [9:0] exp, input logic exp_err);
        logic [9:0] got;
        reset = rst; id_rs = rs; id_rt = rt; ex_rt = ert; ex_memread = emr;
        mem_branch = br; mem_zero = z; mem_memread = mr; mem_memwrite = mw; dmem_ack = ack;
        @(negedge clk);
        got = {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, dmem_req};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s outputs got %b want %b", name, got, exp);
        end
        checks++;
        if (mem_err !== exp_err) begin
            errors++;
            $display("FAIL %s mem_err got %b want %b", name, mem_err, exp_err);
        end
`ifdef PIPE_PERF_CNT_EN
        if (rst) exp_stall = 0;
        else if (!exp[9]) exp_stall++;
`endif
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic check_stall(input string name);
        checks++;
        if (stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, exp_stall);
        end
    endtask
`endif

    initial begin
        //          rs     rt     ert    emr   br    z     mr    mw    ack   exp
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADV};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LDUSE};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADV};
        vecs[3]  = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LDUSE};
        vecs[4]  = '{5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADV};
        vecs[5]  = '{5'd4, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADV};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BRANCH};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ADV};
        vecs[8]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BRANCH};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADV | REQ};
        vecs[10] = '{5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, LDUSE | REQ};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ADV};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, BRANCH | REQ};

        reset = 1'b1; id_rs = 0; id_rt = 0; ex_rt = 0; ex_memread = 0;
        mem_branch = 0; mem_zero = 0; mem_memread = 0; mem_memwrite = 0; dmem_ack = 0;
`ifdef PIPE_PERF_CNT_EN
        exp_stall = 0;
`endif
        @(posedge clk);
        #1;

        // Reset held with a taken branch presented: everything forced low.
        cyc("rst0", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, ZERO, 0);
        cyc("rst1", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, ZERO, 0);
`ifdef PIPE_PERF_CNT_EN
        check_stall("rst");
`endif

        for (int i = 0; i < NV; i++) begin
            cyc($sformatf("vec%0d", i), 0, vecs[i].rs, vecs[i].rt, vecs[i].ert, vecs[i].emr,
                vecs[i].br, vecs[i].z, vecs[i].mr, vecs[i].mw, vecs[i].ack, vecs[i].exp, 0);
        end
`ifdef PIPE_PERF_CNT_EN
        check_stall("table");
`endif

        // Memory wait: ack three cycles after the request.
`ifdef PIPE_PERF_CNT_EN
        exp_stall = stall_cnt;
`endif
        cyc("mw_req",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("mw_w1",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("mw_w2",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("mw_ack",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, ADV | REQ, 0);
        cyc("mw_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0);
`ifdef PIPE_PERF_CNT_EN
        check_stall("mw");
`endif

        // Taken branch deferred to the ack cycle; load-use during the wait is ignored.
        cyc("bd_req",  0, 3, 0, 3, 1, 1, 1, 0, 1, 0, FREEZE, 0);
        cyc("bd_w1",   0, 3, 0, 3, 1, 1, 1, 0, 1, 0, FREEZE, 0);
        cyc("bd_ack",  0, 0, 0, 0, 0, 1, 1, 0, 1, 1, BRANCH | REQ, 0);
        cyc("bd_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0);

        // Watchdog: no ack, abandon on the fourth wait cycle.
        cyc("to_req",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("to_w1",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("to_w2",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("to_w3",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 0);
        cyc("to_w4",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ADV, 0);
        cyc("to_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1);
        cyc("to_br",   0, 0, 0, 0, 0, 1, 1, 0, 0, 0, BRANCH, 1);
        cyc("to_req2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 1);
        cyc("to_ack2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, ADV | REQ, 1);
        cyc("to_keep", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 1);

        // Reset in the middle of a wait drops the request at once and clears mem_err.
        cyc("rw_req",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 1);
        cyc("rw_w1",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE, 1);
        cyc("rw_rst",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, ZERO, 1);
        cyc("rw_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0);
`ifdef PIPE_PERF_CNT_EN
        check_stall("rw");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches signalled from the EX/MEM stage, and multi-cycle data-memory accesses through a req/ack handshake. A watchdog flags memory accesses that never complete.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max cycles in MEM_WAIT before `mem_err` sets; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset; one clock, reset synchronous active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- ex_memread  in  1  MemRead of instruction in EX (ID/EX output)
- ex_rt  in  5  destination register of instruction in EX
- mem_branch  in  1  Branch flag out of EX/MEM
- mem_zero  in  1  zero flag out of EX/MEM
- mem_memread  in  1  MemRead out of EX/MEM
- mem_memwrite  in  1  MemWrite out of EX/MEM
- dmem_ack  in  1  data memory completion, 1-cycle pulse
- pc_en  out  1  PC load enable
- pc_sel_branch  out  1  select EX/MEM branch address as next PC
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load zero/bubble into that register
- dmem_req  out  1  data memory request
- mem_err  out  1  sticky watchdog error
- stall_cnt  out  32  stall cycle count (only with PIPE_PERF_CNT_EN)

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- All outputs are combinational from state and inputs, except `mem_err`, `stall_cnt`, the state and the watchdog counter, which are registers.
- `mem_access` = mem_memread | mem_memwrite.
- RUN with mem_access:
  - `dmem_req` = 1.
  - If `dmem_ack` is also high, the access completes this cycle and normal rules apply.
  - Otherwise: next state MEM_WAIT, all enables 0, all flushes 0.
- MEM_WAIT:
  - `dmem_req` stays 1, all enables 0, all flushes 0.
  - On `dmem_ack`: next state RUN, and the normal rules below apply in this same cycle.
- Normal rules, in priority order:
  1. Taken branch (`mem_branch & mem_zero`): `pc_sel_branch`=1, `pc_en`=1, `ifid_flush`=`idex_flush`=`exmem_flush`=1, all enables 1.
  2. Load-use (`ex_memread` & `ex_rt`≠0 & (`ex_rt`==`id_rs` | `ex_rt`==`id_rt`)): `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=`memwb_en`=1.
  3. Otherwise: all enables 1, all flushes 0, `pc_sel_branch`=0.
- A taken branch during a memory wait is deferred to the ack cycle. A load-use that coincides with a taken branch is discarded.
- Watchdog:
  - The counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - When the count reaches MEM_TIMEOUT: `mem_err` sets, FSM returns to RUN, and the access is abandoned. In that cycle `dmem_req`=0 and the pipeline advances as in rule 3.
  - `mem_err` clears only on reset.
- Flush takes precedence over enable in the target register.

## Timing
- Reset (synchronous): state RUN, watchdog 0, `mem_err` 0, `stall_cnt` 0.
- While `reset` is high, all enables, flushes, `pc_sel_branch` and `dmem_req` are forced to 0, regardless of the other inputs.
- A reset asserted mid-MEM_WAIT abandons the access. `dmem_req` drops in the same cycle.
- Zero-wait memory (ack in the request cycle) adds 0 stall cycles. An ack N cycles later adds N freeze cycles.
- Load-use costs exactly 1 bubble. A taken branch costs 3 squashed instructions.
- An ack arriving in RUN with no access pending is ignored.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt` exists and increments by 1 in every non-reset cycle where `pc_en`=0.
  - It wraps from 0xFFFFFFFF to 0.
- `PIPE_PERF_CNT_EN` undefined: the `stall_cnt` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `mem_branch`=`mem_zero`=1 -> all enables and flushes 0, `mem_err`=0, `stall_cnt`=0.
- Load-use: `ex_memread`=1, `ex_rt`=5, `id_rs`=5 for 1 cycle -> `pc_en`=0, `ifid_en`=0, `idex_flush`=1. Repeat with `ex_rt`=0 -> no stall.
- Memory wait: `mem_memread`=1, `dmem_ack` 3 cycles later -> `dmem_req` high 4 cycles, enables 0 for 3 cycles, enables 1 on the ack cycle, `stall_cnt`=3.
- Branch deferred: `mem_memwrite`=`mem_branch`=`mem_zero`=1, ack after 2 cycles -> `pc_sel_branch` and the three flushes asserted only on the ack cycle.
- Timeout: MEM_TIMEOUT=4, `mem_memread`=1, no ack -> `mem_err` rises after 4 MEM_WAIT cycles, FSM returns to RUN, `mem_err` stays 1 until reset.
- Branch plus load-use in the same cycle -> branch rule only: `pc_en`=1, `ifid_flush`=`idex_flush`=`exmem_flush`=1.
